// File: rtl/mfm_sync_framer.sv
`default_nettype none
// ============================================================================
//  Module   : mfm_sync_framer
//  Purpose  : MFM front end. Times flux transitions on clk_50, classifies each
//             interval as 2/3/4 cells, hunts for the missing-clock sync word
//             and frames the following cell stream into data bytes.
//  Revision : 1.0  initial release
// ============================================================================
module mfm_sync_framer #(
  parameter int          CELL_CLKS = 5,
  parameter logic [15:0] SYNC_WORD = 16'h4489,
  parameter int          MAX_BYTES = 1024,
  parameter int          CNT_W     = 8
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             raw_mfm,
  input  logic             enable,
  input  logic             err_clr,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic             sync_mark,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count
);

  localparam int BC_W = $clog2(MAX_BYTES + 1);

  // Interval class boundaries, compared against twice the interval count
  localparam logic [CNT_W:0]   C_LIM_SHORT = (CNT_W+1)'(3 * CELL_CLKS);
  localparam logic [CNT_W:0]   C_LIM_2     = (CNT_W+1)'(5 * CELL_CLKS);
  localparam logic [CNT_W:0]   C_LIM_3     = (CNT_W+1)'(7 * CELL_CLKS);
  localparam logic [CNT_W:0]   C_LIM_4     = (CNT_W+1)'(9 * CELL_CLKS);
  // ceil(4.5 cells): first count that can no longer be a legal interval
  localparam logic [CNT_W-1:0] C_LONG      = CNT_W'((9 * CELL_CLKS + 1) / 2);
  localparam logic [BC_W-1:0]  C_LAST_BYTE = BC_W'(MAX_BYTES - 1);

  typedef enum logic [0:0] {
    S_HUNT = 1'b0,
    S_DATA = 1'b1
  } state_t;

  logic [2:0]       sync_q;
  logic [CNT_W-1:0] icnt_q;
  logic             armed_q;
  logic [2:0]       emit_q;
  logic [15:0]      sreg_q;
  logic [15:0]      sreg_d;
  logic [3:0]       cell_cnt_q;
  logic [BC_W-1:0]  byte_cnt_q;
  state_t           state_q;
  logic [7:0]       byte_out_q;
  logic             byte_valid_q;
  logic             sync_mark_q;
  logic             err_pulse_q;
  logic [CNT_W-1:0] err_count_q;

  logic             w_edge;
  logic [CNT_W:0]   w_twice;
  logic [2:0]       w_ncells;
  logic             w_short_err;
  logic             w_long_err;
  logic             w_err;
  logic             w_shift;
  logic             w_match;
  logic [7:0]       w_data;

  // Two-flop synchroniser plus a delay flop for rising-edge detection
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[1:0], raw_mfm};
  end

  assign w_edge = enable & sync_q[1] & ~sync_q[2];

  // Interval timer; it only runs once an edge has given it a reference point
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      icnt_q  <= '0;
      armed_q <= 1'b0;
    end else if (!enable) begin
      icnt_q  <= '0;
      armed_q <= 1'b0;
    end else if (w_edge) begin
      icnt_q  <= CNT_W'(1);
      armed_q <= 1'b1;
    end else if (w_long_err) begin
      armed_q <= 1'b0;
    end else if (armed_q && (icnt_q != '1)) begin
      icnt_q  <= icnt_q + CNT_W'(1);
    end
  end

  // Classify the interval closed by this edge into a cell count or an error
  always_comb begin
    w_twice     = {icnt_q, 1'b0};
    w_ncells    = 3'd0;
    w_short_err = 1'b0;
    if (w_edge && armed_q) begin
      if (w_twice < C_LIM_SHORT)  w_short_err = 1'b1;
      else if (w_twice < C_LIM_2) w_ncells    = 3'd2;
      else if (w_twice < C_LIM_3) w_ncells    = 3'd3;
      else if (w_twice < C_LIM_4) w_ncells    = 3'd4;
    end
  end

  assign w_long_err = enable & armed_q & (icnt_q == C_LONG);
  assign w_err      = w_short_err | w_long_err;

  // Emitter shifts one cell per clock: zeros first, the final cell is a one
  assign w_shift = enable & ~w_err & (emit_q != 3'd0);
  assign sreg_d  = {sreg_q[14:0], (emit_q == 3'd1)};
  assign w_match = w_shift & (sreg_d == SYNC_WORD);

  // Data bits sit on the even cell positions of the freshly shifted register
  always_comb begin
    w_data = 8'h00;
    for (int b = 0; b < 8; b++) begin
      w_data[b] = sreg_d[2*b];
    end
  end

  // Framing FSM with registered strobes and saturating error counter
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q      <= S_HUNT;
      sreg_q       <= '0;
      emit_q       <= '0;
      cell_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      sync_mark_q  <= 1'b0;
      err_pulse_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      byte_valid_q <= 1'b0;
      sync_mark_q  <= 1'b0;
      err_pulse_q  <= 1'b0;

      if (err_clr) begin
        err_count_q <= '0;
      end else if (enable && w_err && (state_q == S_DATA) && (err_count_q != '1)) begin
        err_count_q <= err_count_q + CNT_W'(1);
      end

      if (!enable) begin
        state_q    <= S_HUNT;
        sreg_q     <= '0;
        emit_q     <= '0;
        cell_cnt_q <= '0;
      end else if (w_err) begin
        // Pending cells and any partial byte are abandoned
        sreg_q     <= '0;
        emit_q     <= '0;
        cell_cnt_q <= '0;
        if (state_q == S_DATA) begin
          err_pulse_q <= 1'b1;
          state_q     <= S_HUNT;
        end
      end else begin
        if (w_ncells != 3'd0)    emit_q <= w_ncells;
        else if (emit_q != 3'd0) emit_q <= emit_q - 3'd1;

        if (w_shift) begin
          sreg_q <= sreg_d;
          if (w_match) begin
            // A sync at any alignment realigns byte framing
            byte_valid_q <= 1'b1;
            sync_mark_q  <= 1'b1;
            byte_out_q   <= 8'hA1;
            state_q      <= S_DATA;
            cell_cnt_q   <= '0;
            byte_cnt_q   <= '0;
          end else if (state_q == S_DATA) begin
            if (cell_cnt_q == 4'd15) begin
              byte_valid_q <= 1'b1;
              byte_out_q   <= w_data;
              cell_cnt_q   <= '0;
              byte_cnt_q   <= byte_cnt_q + BC_W'(1);
              if (byte_cnt_q == C_LAST_BYTE) state_q <= S_HUNT;
            end else begin
              cell_cnt_q <= cell_cnt_q + 4'd1;
            end
          end
        end
      end
    end
  end

  assign byte_out   = byte_out_q;
  assign byte_valid = byte_valid_q;
  assign sync_mark  = sync_mark_q;
  assign err_pulse  = err_pulse_q;
  assign err_count  = err_count_q;
  assign locked     = (state_q == S_DATA);

endmodule
`default_nettype wire

// File: tb/tb_mfm_sync_framer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mfm_sync_framer
//  Purpose  : Scoreboard bench for mfm_sync_framer. Streams are MFM-encoded
//             from bytes, turned into flux intervals, and a cell-level model
//             predicts the byte and error strobes.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mfm_sync_framer;

  localparam int          C       = 5;
  localparam int          TB_MAX  = 4;
  localparam int          CW      = 8;
  localparam int          ERR_MAX = (1 << CW) - 1;
  localparam logic [15:0] SYNC    = 16'h4489;

  logic          clk = 1'b0;
  logic          reset;
  logic          raw;
  logic          enable;
  logic          err_clr;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic          sync_mark;
  logic          locked;
  logic          err_pulse;
  logic [CW-1:0] err_count;

  always #10 clk = ~clk;

  mfm_sync_framer #(
    .CELL_CLKS (C),
    .SYNC_WORD (SYNC),
    .MAX_BYTES (TB_MAX),
    .CNT_W     (CW)
  ) dut (
    .clk_50     (clk),
    .reset      (reset),
    .raw_mfm    (raw),
    .enable     (enable),
    .err_clr    (err_clr),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .sync_mark  (sync_mark),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .err_count  (err_count)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [8:0] exp_byte[$];   // {sync_mark, byte}
  int         exp_err[$];    // err_count expected with each err_pulse
  int         m_err    = 0;
  bit         g_cells[$];
  bit         g_prev;
  int         g_iv[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes
  always @(negedge clk) begin
    if (byte_valid) begin
      if (exp_byte.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_byte: got 0x%0h sync=%0d, required no strobe", byte_out, sync_mark);
      end else begin
        check("byte", int'({sync_mark, byte_out}), int'(exp_byte.pop_front()));
        if (sync_mark) check("locked_at_sync", int'(locked), 1);
      end
    end
    if (err_pulse) begin
      if (exp_err.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_err: got err_count %0d, required no err_pulse", err_count);
      end else begin
        check("err_count_at_pulse", int'(err_count), exp_err.pop_front());
        check("locked_after_err", int'(locked), 0);
      end
    end
  end

  // ---------------- stream construction ----------------
  task automatic new_stream();
    g_cells = {};
    g_prev  = 1'b0;
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      g_cells.push_back(!g_prev && !b[i]);
      g_cells.push_back(b[i]);
      g_prev = b[i];
    end
  endtask

  task automatic add_sync();
    logic [15:0] s;
    s = SYNC;
    for (int i = 15; i >= 0; i--) g_cells.push_back(s[i]);
    g_prev = 1'b1;
  endtask

  // First '1' is the reference edge; each later '1' closes an interval
  task automatic cells_to_iv(input bit jitter);
    int gap;
    bit primed;
    gap = 0; primed = 1'b0; g_iv = {};
    foreach (g_cells[k]) begin
      if (!primed) begin
        if (g_cells[k]) begin primed = 1'b1; g_iv.push_back(0); end
      end else begin
        gap++;
        if (g_cells[k]) begin
          g_iv.push_back(gap * C + (jitter ? int'($urandom_range(0, 4)) - 2 : 0));
          gap = 0;
        end
      end
    end
  endtask

  function automatic logic [7:0] even_bits(input logic [15:0] w);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = w[2*b];
    return r;
  endfunction

  // Reference: cells from interval lengths, sliding 16-cell window framing
  task automatic model_stream();
    logic [15:0] win;
    bit          data;
    int          cc, bc, tw, n;
    win = '0; data = 1'b0; cc = 0; bc = 0;
    for (int k = 1; k < g_iv.size(); k++) begin
      tw = 2 * g_iv[k];
      if (tw < 3 * C) begin
        if (data) begin
          if (m_err < ERR_MAX) m_err++;
          exp_err.push_back(m_err);
        end
        data = 1'b0; win = '0; cc = 0;
      end else begin
        n = (tw < 5 * C) ? 2 : ((tw < 7 * C) ? 3 : 4);
        for (int j = 1; j <= n; j++) begin
          win = {win[14:0], (j == n)};
          if (win == SYNC) begin
            exp_byte.push_back({1'b1, 8'hA1});
            data = 1'b1; cc = 0; bc = 0;
          end else if (data) begin
            cc++;
            if (cc == 16) begin
              exp_byte.push_back({1'b0, even_bits(win)});
              cc = 0; bc++;
              if (bc == TB_MAX) data = 1'b0;
            end
          end
        end
      end
    end
    // Stream end leaves a gap that times out
    if (data) begin
      if (m_err < ERR_MAX) m_err++;
      exp_err.push_back(m_err);
    end
  endtask

  task automatic drive_iv();
    for (int k = 0; k < g_iv.size(); k++) begin
      if (k > 0) repeat (g_iv[k] - 2) @(negedge clk);
      raw = 1'b1;
      repeat (2) @(negedge clk);
      raw = 1'b0;
    end
  endtask

  task automatic run_stream(input string name);
    model_stream();
    drive_iv();
    repeat (60) @(negedge clk);
    check({name, "_bytes_pending"}, exp_byte.size(), 0);
    check({name, "_errs_pending"}, exp_err.size(), 0);
  endtask

  task automatic sync_stream(input logic [7:0] d[$], input bit jitter);
    new_stream();
    add_byte(8'h00); add_byte(8'h00);
    add_sync();
    foreach (d[i]) add_byte(d[i]);
    add_byte(8'h00);
    cells_to_iv(jitter);
  endtask

  initial begin
    logic [7:0] d[$];
    reset = 1'b1; raw = 1'b0; enable = 1'b1; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_byte_valid", int'(byte_valid), 0);
    check("reset_locked", int'(locked), 0);
    check("reset_err_count", int'(err_count), 0);
    check("reset_byte_out", int'(byte_out), 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Sync alone, then the trailer gap times out while locked
    d = {}; sync_stream(d, 1'b0); run_stream("sync_only");
    check("unlocked_after_gap", int'(locked), 0);

    d = {8'hFE, 8'h00, 8'h5A}; sync_stream(d, 1'b0); run_stream("three_bytes");
    d = {8'hFE, 8'h00, 8'h5A}; sync_stream(d, 1'b1); run_stream("three_bytes_jitter");

    // Byte limit: bytes beyond TB_MAX are dropped, no error at the gap
    d = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}; sync_stream(d, 1'b0); run_stream("byte_limit");

    // Second sync inside DATA restarts the byte count
    new_stream();
    add_byte(8'h00); add_byte(8'h00); add_sync();
    add_byte(8'h3C); add_byte(8'hC3); add_byte(8'h00); add_sync();
    add_byte(8'h11); add_byte(8'h22); add_byte(8'h33); add_byte(8'h00);
    cells_to_iv(1'b0); run_stream("resync");

    for (int r = 0; r < 6; r++) begin
      d = {};
      repeat ($urandom_range(0, 6)) d.push_back(8'($urandom));
      sync_stream(d, 1'b1);
      run_stream("random");
    end

    // Disabled: no strobes, no errors
    enable = 1'b0;
    d = {8'h77}; sync_stream(d, 1'b0); drive_iv();
    enable = 1'b1;
    repeat (60) @(negedge clk);
    check("disabled_locked", int'(locked), 0);
    check("disabled_bytes", exp_byte.size(), 0);

    // Repeated sync + 6-clk interval: counter saturates
    g_iv = {0};
    repeat (ERR_MAX + 2) begin
      g_iv.push_back(10); g_iv.push_back(20); g_iv.push_back(15);
      g_iv.push_back(20); g_iv.push_back(15); g_iv.push_back(6);
    end
    run_stream("saturate");
    check("err_count_saturated", int'(err_count), ERR_MAX);

    // Asynchronous reset mid-byte
    d = {8'hFE}; sync_stream(d, 1'b0);
    repeat (10) void'(g_iv.pop_back());
    model_stream();
    drive_iv();
    repeat (5) @(negedge clk);
    check("locked_before_reset", int'(locked), 1);
    #3 reset = 1'b1;
    #1;
    check("async_reset_locked", int'(locked), 0);
    check("async_reset_err_count", int'(err_count), 0);
    check("async_reset_byte_valid", int'(byte_valid), 0);
    exp_byte = {}; exp_err = {}; m_err = 0;
    @(negedge clk); reset = 1'b0;
    repeat (60) @(negedge clk);

    // err_clr returns the count to zero
    d = {}; sync_stream(d, 1'b0); run_stream("pre_clear");
    check("err_count_before_clr", int'(err_count), 1);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    m_err = 0;
    check("err_count_after_clr", int'(err_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
